// File: rtl/lbus_arbiter.sv
// Two-requester arbiter/sequencer for the local register bus (lbus).
// Build option: define LBUS_ARB_FIXED_PRI_EN to make m0 always win contention.
module lbus_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              lb_rd_en,
    output logic              lb_wr_en,
    output logic [ADDR_W-1:0] lb_address,
    output logic [DATA_W-1:0] lb_wdata,
    input  logic [DATA_W-1:0] lb_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic              grant_q, grant_d;          // 0 = m0, 1 = m1
    logic              last_grant_q, last_grant_d;
    logic              we_q, we_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              lb_rd_en_q, lb_rd_en_d;
    logic              lb_wr_en_q, lb_wr_en_d;
    logic [ADDR_W-1:0] lb_address_q, lb_address_d;
    logic [DATA_W-1:0] lb_wdata_q, lb_wdata_d;
    logic              m0_ack_q, m0_ack_d;
    logic              m1_ack_q, m1_ack_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
    logic              sel;

    // Winner for this IDLE cycle; only meaningful when some req is high.
    always_comb begin
`ifdef LBUS_ARB_FIXED_PRI_EN
        sel = ~m0_req;
`else
        if (m0_req && m1_req) sel = ~last_grant_q;
        else                  sel = m1_req;
`endif
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        cnt_d        = cnt_q;
        lb_rd_en_d   = 1'b0;
        lb_wr_en_d   = 1'b0;
        lb_address_d = lb_address_q;
        lb_wdata_d   = lb_wdata_q;
        m0_ack_d     = 1'b0;
        m1_ack_d     = 1'b0;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    grant_d      = sel;
                    we_d         = sel ? m1_we : m0_we;
                    lb_address_d = sel ? m1_addr : m0_addr;
                    lb_wdata_d   = sel ? m1_wdata : m0_wdata;
                    lb_wr_en_d   = we_d;
                    lb_rd_en_d   = ~we_d;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    m0_ack_d = ~grant_q;
                    m1_ack_d = grant_q;
                    state_d  = DONE;
                end else begin
                    cnt_d   = 4'(RD_LAT);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // lb_rdata is valid in the cycle the counter sits at 1
                if (cnt_q <= 4'd1) begin
                    if (grant_q) m1_rdata_d = lb_rdata;
                    else         m0_rdata_d = lb_rdata;
                    m0_ack_d = ~grant_q;
                    m1_ack_d = grant_q;
                    state_d  = DONE;
                end
            end
            DONE: begin
                last_grant_d = grant_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            cnt_q        <= '0;
            lb_rd_en_q   <= 1'b0;
            lb_wr_en_q   <= 1'b0;
            lb_address_q <= '0;
            lb_wdata_q   <= '0;
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            cnt_q        <= cnt_d;
            lb_rd_en_q   <= lb_rd_en_d;
            lb_wr_en_q   <= lb_wr_en_d;
            lb_address_q <= lb_address_d;
            lb_wdata_q   <= lb_wdata_d;
            m0_ack_q     <= m0_ack_d;
            m1_ack_q     <= m1_ack_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
        end
    end

    assign lb_rd_en   = lb_rd_en_q;
    assign lb_wr_en   = lb_wr_en_q;
    assign lb_address = lb_address_q;
    assign lb_wdata   = lb_wdata_q;
    assign m0_ack     = m0_ack_q;
    assign m1_ack     = m1_ack_q;
    assign m0_rdata   = m0_rdata_q;
    assign m1_rdata   = m1_rdata_q;

endmodule

// File: tb/tb_lbus_arbiter.sv
// Randomized scoreboard bench for lbus_arbiter with a register-map model on the lbus side.
`timescale 1ns/1ps
module tb_lbus_arbiter;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int RD_LAT = 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              m0_req = 1'b0, m0_we = 1'b0;
    logic [ADDR_W-1:0] m0_addr = '0;
    logic [DATA_W-1:0] m0_wdata = '0;
    logic              m1_req = 1'b0, m1_we = 1'b0;
    logic [ADDR_W-1:0] m1_addr = '0;
    logic [DATA_W-1:0] m1_wdata = '0;
    logic [DATA_W-1:0] lb_rdata = '0;
    logic              m0_ack, m1_ack, lb_rd_en, lb_wr_en;
    logic [DATA_W-1:0] m0_rdata, m1_rdata, lb_wdata;
    logic [ADDR_W-1:0] lb_address;

    int n_checks = 0;
    int n_fails  = 0;

    lbus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .lb_rd_en(lb_rd_en), .lb_wr_en(lb_wr_en), .lb_address(lb_address),
        .lb_wdata(lb_wdata), .lb_rdata(lb_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rdata;
    } txn_t;

    txn_t exp_q0[$];
    txn_t exp_q1[$];

    // Read-only contents of the modelled register map
    function automatic logic [DATA_W-1:0] rom(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5F;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Issue one transaction for master m and wait (bounded) for its ack.
    task automatic do_txn(input int m, input bit we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wd);
        txn_t t;
        bit   got;
        t.we = we; t.addr = addr; t.wdata = wd; t.rdata = rom(addr);
        if (m == 0) begin
            m0_we = we; m0_addr = addr; m0_wdata = wd; m0_req = 1'b1; exp_q0.push_back(t);
        end else begin
            m1_we = we; m1_addr = addr; m1_wdata = wd; m1_req = 1'b1; exp_q1.push_back(t);
        end
        got = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (((m == 0) ? m0_ack : m1_ack) === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        chk($sformatf("ack_seen_m%0d", m), 64'(got), 64'(1));
        @(posedge clk); #1;
        if (m == 0) m0_req = 1'b0; else m1_req = 1'b0;
    endtask

    // Monitor + lbus register-map model, both evaluated mid-cycle.
    initial begin : monitor
        bit                busy, exp_strobe, exp_owner, owner, last_owner, strobe, is_idle, due, have;
        int                mcyc, ack_due;
        logic [ADDR_W-1:0] addr_hold;
        logic [DATA_W-1:0] wdata_hold, rd_hold0, rd_hold1;
        bit                hv[16];
        logic [ADDR_W-1:0] ha[16];
        txn_t              t;
        busy = 0; exp_strobe = 0; exp_owner = 0; owner = 0; last_owner = 1;
        mcyc = 0; ack_due = 0; addr_hold = '0; wdata_hold = '0; rd_hold0 = '0; rd_hold1 = '0;
        t.we = 0; t.addr = '0; t.wdata = '0; t.rdata = '0;
        for (int i = 0; i < 16; i++) begin hv[i] = 0; ha[i] = '0; end
        forever begin
            @(negedge clk);
            mcyc++;
            if (!rst_n) begin
                chk("reset_outputs", 64'({m0_ack, m1_ack, lb_rd_en, lb_wr_en, lb_address,
                                          lb_wdata, m0_rdata, m1_rdata}), 64'(0));
                busy = 0; exp_strobe = 0; last_owner = 1;
                addr_hold = '0; wdata_hold = '0; rd_hold0 = '0; rd_hold1 = '0;
                for (int i = 0; i < 16; i++) hv[i] = 0;
                lb_rdata = DATA_W'($urandom);
            end else begin
                is_idle = !busy && !exp_strobe;
                strobe  = lb_rd_en | lb_wr_en;
                chk("strobe_exclusive", 64'(lb_rd_en & lb_wr_en), 64'(0));
                if (exp_strobe) begin
                    chk("strobe_due", 64'(strobe), 64'(1));
                    owner = exp_owner;
                    have  = (owner == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
                    chk("grant_to_requester", 64'(have), 64'(1));
                    if (have) begin
                        t = (owner == 0) ? exp_q0[0] : exp_q1[0];
                        chk("strobe_dir_we", 64'(lb_wr_en), 64'(t.we));
                        chk("strobe_addr", 64'(lb_address), 64'(t.addr));
                        if (t.we) chk("strobe_wdata", 64'(lb_wdata), 64'(t.wdata));
                    end else begin
                        t.we = lb_wr_en;
                    end
                    busy       = 1;
                    ack_due    = mcyc + (t.we ? 1 : 1 + RD_LAT);
                    addr_hold  = lb_address;
                    wdata_hold = lb_wdata;
                end else begin
                    chk("no_stray_strobe", 64'(strobe), 64'(0));
                    chk("addr_held", 64'(lb_address), 64'(addr_hold));
                    chk("wdata_held", 64'(lb_wdata), 64'(wdata_hold));
                end
                due = busy && (mcyc == ack_due);
                chk("m0_ack", 64'(m0_ack), 64'(due && owner == 0));
                chk("m1_ack", 64'(m1_ack), 64'(due && owner == 1));
                if (due) begin
                    if (owner == 0 && exp_q0.size() > 0) t = exp_q0.pop_front();
                    if (owner == 1 && exp_q1.size() > 0) t = exp_q1.pop_front();
                    if (!t.we) begin
                        if (owner == 0) rd_hold0 = t.rdata; else rd_hold1 = t.rdata;
                    end
                    busy       = 0;
                    last_owner = owner;
                end
                chk("m0_rdata", 64'(m0_rdata), 64'(rd_hold0));
                chk("m1_rdata", 64'(m1_rdata), 64'(rd_hold1));
                // Winner for the next cycle's strobe: single requester wins, else alternate
                exp_strobe = is_idle && (m0_req || m1_req);
`ifdef LBUS_ARB_FIXED_PRI_EN
                exp_owner = !m0_req;
`else
                if (m0_req && m1_req) exp_owner = !last_owner;
                else                  exp_owner = m1_req;
`endif
                // Register map: data valid exactly RD_LAT cycles after the read strobe
                for (int i = 15; i > 0; i--) begin hv[i] = hv[i-1]; ha[i] = ha[i-1]; end
                hv[0] = lb_rd_en;
                ha[0] = lb_address;
                lb_rdata = hv[RD_LAT] ? rom(ha[RD_LAT]) : DATA_W'($urandom);
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Isolated write from m0, isolated read from m1
        do_txn(0, 1'b1, 16'h0010, 8'hA5);
        do_txn(1, 1'b0, 16'h0003, 8'h00);
        chk("m1_read_0x0003", 64'(m1_rdata), 64'(8'h5C));

        // Contention: both request together; m0 re-requests immediately afterwards
        fork
            begin do_txn(0, 1'b1, 16'h0100, 8'h11); do_txn(0, 1'b1, 16'h0101, 8'h22); end
            begin do_txn(1, 1'b1, 16'h0200, 8'h33); end
        join

        // m1 raises its request while m0's read is waiting for data
        fork
            begin do_txn(0, 1'b0, 16'h1234, 8'h00); end
            begin @(posedge clk); @(posedge clk); #1; do_txn(1, 1'b1, 16'h0300, 8'h44); end
        join

        // Sustained contention: m0 back-to-back for 4 transactions, m1 waiting
        fork
            begin for (int i = 0; i < 4; i++) do_txn(0, 1'b1, 16'(16'h0400 + i), 8'(i)); end
            begin do_txn(1, 1'b0, 16'h0500, 8'h00); end
        join

        // Reset while a read sits in WAIT
        m0_we = 1'b0; m0_addr = 16'h0042; m0_wdata = 8'h00; m0_req = 1'b1;
        begin
            txn_t t;
            t.we = 0; t.addr = 16'h0042; t.wdata = 8'h00; t.rdata = rom(16'h0042);
            exp_q0.push_back(t);
        end
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("reset_mid_read", 64'({m0_ack, m1_ack, lb_rd_en, lb_wr_en, lb_address,
                                      lb_wdata, m0_rdata, m1_rdata}), 64'(0));
        m0_req = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        do_txn(0, 1'b0, 16'h0077, 8'h00);

        // Randomized traffic from both masters
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    do_txn(0, 1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom));
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                end
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    do_txn(1, 1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom));
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                end
            end
        join

        repeat (5) @(posedge clk);
        chk("queue0_drained", 64'(exp_q0.size()), 64'(0));
        chk("queue1_drained", 64'(exp_q1.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
